// File: rtl/color_palette_mapper.sv
// Palette lookup with a two-stage registered pipeline and an optional blink that
// blanks every pixel except the background index.
module color_palette_mapper #(
  parameter int COLOR_W      = 8,
  parameter int IDX_W        = 2,
  parameter int BLINK_PERIOD = 25000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pal_we,
  input  logic [IDX_W-1:0]     pal_addr,
  input  logic [3*COLOR_W-1:0] pal_data,
  input  logic                 blink_en,
  input  logic                 pix_valid,
  input  logic [IDX_W-1:0]     pix_idx,
  output logic                 pix_valid_out,
  output logic [COLOR_W-1:0]   red_out,
  output logic [COLOR_W-1:0]   green_out,
  output logic [COLOR_W-1:0]   blue_out
);
  localparam int DEPTH = 2 ** IDX_W;
  localparam int DW    = 3 * COLOR_W;
  localparam int CW    = $clog2(BLINK_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_PERIOD - 1);

  logic [DW-1:0] pal_q [DEPTH];
  logic [DW-1:0] pal_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_blank_q, s1_blank_d;
  logic [DW-1:0] s1_color_q, s1_color_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_color_q, out_color_d;

  always_comb begin
    pal_d = pal_q;
    if (pal_we) pal_d[pal_addr] = pal_data;
  end

  // Phase 0 is visible, phase 1 blanks; disabling returns to the visible phase.
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (blink_en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
      end
    end
  end

  // The read uses pal_q, so a same-edge write is seen only by later pixels.
  always_comb begin
    s1_valid_d  = pix_valid;
    s1_color_d  = pal_q[pix_idx];
    s1_blank_d  = blink_en & phase_q & (pix_idx != '0);
    out_valid_d = s1_valid_q;
    out_color_d = (s1_valid_q && !s1_blank_q) ? s1_color_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pal_q[i] <= (i == 0) ? '0 : '1;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_blank_q  <= 1'b0;
      s1_color_q  <= '0;
      out_valid_q <= 1'b0;
      out_color_q <= '0;
    end else begin
      pal_q       <= pal_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      s1_valid_q  <= s1_valid_d;
      s1_blank_q  <= s1_blank_d;
      s1_color_q  <= s1_color_d;
      out_valid_q <= out_valid_d;
      out_color_q <= out_color_d;
    end
  end

  assign pix_valid_out = out_valid_q;
  assign red_out       = out_color_q[DW-1 -: COLOR_W];
  assign green_out     = out_color_q[2*COLOR_W-1 -: COLOR_W];
  assign blue_out      = out_color_q[COLOR_W-1:0];
endmodule

// File: doc/color_palette_mapper.md
Name: color_palette_mapper

Overview:
- Parametrised successor to the switch-driven colour converter.
- Maps a per-pixel palette index to a registered RGB triple through a writable palette of 2**IDX_W entries.
- Adds an optional blink mode that periodically blanks all non-background pixels.
- Sits between the pixel generator and the video output encoder, in the pixel clock domain.

Parameters:
- COLOR_W, 8, bits per colour channel.
- IDX_W, 2, palette index width; palette depth = 2**IDX_W.
- BLINK_PERIOD, 25000000, clk cycles per blink half-period; must be >= 2.

Ports:
- clk  input  1  pixel clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- pal_we  input  1  palette write enable.
- pal_addr  input  IDX_W  palette entry to write.
- pal_data  input  3*COLOR_W  {red, green, blue}; red in the MSBs.
- blink_en  input  1  enable blink mode.
- pix_valid  input  1  pixel index valid this cycle.
- pix_idx  input  IDX_W  palette index of the pixel.
- pix_valid_out  output  1  output colour valid.
- red_out  output  COLOR_W  red channel.
- green_out  output  COLOR_W  green channel.
- blue_out  output  COLOR_W  blue channel.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pix_valid_out=0; red_out, green_out and blue_out = 0.
  - Pipeline valid bits cleared; blink counter = 0; blink_phase = 0.
  - Palette entry 0 = all zeros (black); every other entry = all ones (white).
  - Equivalent to the old in_color=1, all switches on.
- Reset mid-stream: in-flight pixels are dropped (no output valid for them); palette is reinitialised.
- Palette write: on an edge with pal_we=1, entry[pal_addr] <= pal_data. A write takes effect for pixels sampled on later edges.
- Pipeline: fixed 2-cycle latency, no backpressure, one pixel per cycle.
  - Stage 1 (edge T): register pix_valid and the palette entry read combinationally at pix_idx, using palette contents before any write at edge T. Also register blank = blink_en & blink_phase & (pix_idx != 0).
  - Stage 2 (edge T+1): pix_valid_out <= stage-1 valid. Colour outputs <= 0 if blank, else the stored entry.
  - Outputs are visible after edge T+1, i.e. 2 edges after input presentation.
- Write/read collision: a pixel sampled on the same edge as a write to its index returns the old entry. The next pixel returns the new entry.
- Invalid cycles:
  - pix_valid=0 produces pix_valid_out=0 two cycles later.
  - Colour outputs are forced to 0 whenever the stage-2 valid is 0, so blanking intervals are black.
- Blink:
  - blink_en=0: counter and blink_phase held at 0; no blanking.
  - blink_en=1: counter increments each cycle. When it reaches BLINK_PERIOD-1 it wraps to 0 and blink_phase toggles. Phase 0 = visible, phase 1 = blanked.
  - Deasserting blink_en clears counter and phase on the next edge. Re-enabling starts again in the visible phase.
  - Index 0 (background) is never affected by blink.
- Counter width: $clog2(BLINK_PERIOD). All arithmetic is unsigned, with no overflow beyond the wrap point.

Test Plan:
1. Reset then stream pix_idx 0,1,2,3 with valid=1 (COLOR_W=8) -> 2 cycles later outputs 000000, FFFFFF, FFFFFF, FFFFFF per channel with pix_valid_out=1 each cycle.
2. Write entry2 = {8'h12,8'h34,8'h56}, then present idx 2 -> red=0x12, green=0x34, blue=0x56 at latency 2. Same-edge write plus idx 2 read -> old 0xFF values, with the next pixel giving the new values.
3. Toggle pix_valid 1,0,1 with idx 3 -> pix_valid_out 1,0,1; colours 0 on the invalid cycle.
4. BLINK_PERIOD=4, blink_en=1, continuous idx 1 -> outputs alternate white for 4 cycles and black for 4 cycles. Idx 0 stays black throughout. Dropping blink_en restores white 2 cycles later.
5. Assert rst_n=0 for one edge mid-stream after writing entry1 = 0x0A0B0C -> pix_valid_out=0 and colours 0 the next cycle. Idx 1 afterwards returns FFFFFF.
6. Parameter sweep IDX_W=3, COLOR_W=4: write all 8 entries with distinct values and read back in random order -> each output matches the written entry at latency 2.
